// File: rtl/hinp_cfg_pkg.sv
// Shared types and constants for the HINP4 configuration loader: FSM states, default width,
// and the named bit positions of the 48-bit configuration word.
package hinp_cfg_pkg;

    localparam int CFG_WIDTH_DEF = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int TESTMODE_PEAK_HG = 30;
    localparam int PULSER_HG        = 31;
    localparam int HOLES            = 32;
    localparam int FOUR_USEC_L      = 33;
    localparam int TESTMODE_CORE    = 34;
    localparam int TESTMODE_CSA     = 35;
    localparam int USE_EVEN_PULSER  = 36;
    localparam int TESTMODE_PEAK    = 37;
    localparam int TESTMODE_SHAPER  = 38;
    localparam int USE_ODD_PULSER   = 39;
    localparam int CHIP_ID_LSB      = 40;
    localparam int CHIP_ID_MSB      = 47;

endpackage

// File: rtl/hinp_cfg_phase_timer.sv
// Half-period down-counter: load restarts it at HALF_PERIOD-1, expire is high on the last
// cycle of the phase; one timer serves both the sclk-low and sclk-high phases.
module hinp_cfg_phase_timer #(
    parameter int HALF_PERIOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);
    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/hinp_cfg_loader.sv
// HINP4 config loader: start/busy/done handshake, word shifted MSB-first on sinp under a generated sclk;
// outputs registered one cycle behind the FSM, done at start+1+2*HALF_PERIOD*CFG_WIDTH; readback via HINP_CFG_READBACK_EN.
module hinp_cfg_loader
    import hinp_cfg_pkg::*;
#(
    parameter int CFG_WIDTH   = CFG_WIDTH_DEF,
    parameter int HALF_PERIOD = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CFG_WIDTH-1:0] cfg_word,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic                 sinp,
    output logic                 sclk
`ifdef HINP_CFG_READBACK_EN
    ,
    input  logic                 sout,
    output logic [CFG_WIDTH-1:0] rb_word,
    output logic                 rb_match
`endif
);
    localparam int IW = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(CFG_WIDTH - 1);

    state_t               state_q, state_d;
    logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 sinp_q, sinp_d;
    logic                 sclk_q, sclk_d;
    logic                 active, accept, abort_hit;
    logic                 tmr_load, tmr_expire;

    assign active    = (state_q == ST_SETUP) || (state_q == ST_HIGH);
    assign accept    = (state_q == ST_IDLE) && start;
    assign abort_hit = active && abort;
    assign tmr_load  = (state_d != state_q) && ((state_d == ST_SETUP) || (state_d == ST_HIGH));

    hinp_cfg_phase_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .expire(tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    cfg_d   = cfg_word;
                    idx_d   = IDX_TOP;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire) begin
                    if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                        idx_d   = idx_q - IW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pins follow the state one cycle later; an abort clears them on the same edge it is seen.
    always_comb begin
        busy_d    = active && !abort_hit;
        sclk_d    = (state_q == ST_HIGH) && !abort_hit;
        sinp_d    = active && !abort_hit && cfg_q[idx_q];
        done_d    = (state_q == ST_DONE);
        aborted_d = abort_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            sinp_q    <= 1'b0;
            sclk_q    <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            sinp_q    <= sinp_d;
            sclk_q    <= sclk_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign sinp    = sinp_q;
    assign sclk    = sclk_q;

`ifdef HINP_CFG_READBACK_EN
    // sout is sampled on HIGH entry, i.e. before the chip sees the matching sclk rise.
    logic [CFG_WIDTH-1:0] rb_sh_q, rb_sh_d;
    logic [CFG_WIDTH-1:0] rb_word_q, rb_word_d;
    logic [CFG_WIDTH-1:0] prev_q, prev_d;
    logic                 rb_match_q, rb_match_d;

    always_comb begin
        rb_sh_d    = rb_sh_q;
        rb_word_d  = rb_word_q;
        prev_d     = prev_q;
        rb_match_d = rb_match_q;
        if ((state_q == ST_SETUP) && (state_d == ST_HIGH)) begin
            rb_sh_d = {rb_sh_q[CFG_WIDTH-2:0], sout};
        end
        if (state_q == ST_DONE) begin
            rb_word_d  = rb_sh_q;
            rb_match_d = (rb_sh_q == prev_q);
            prev_d     = cfg_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_sh_q    <= '0;
            rb_word_q  <= '0;
            prev_q     <= '0;
            rb_match_q <= 1'b0;
        end else begin
            rb_sh_q    <= rb_sh_d;
            rb_word_q  <= rb_word_d;
            prev_q     <= prev_d;
            rb_match_q <= rb_match_d;
        end
    end

    assign rb_word  = rb_word_q;
    assign rb_match = rb_match_q;
`else
    // Write-only build: no readback shift register or previous-word store.
`endif

endmodule
